// File: rtl/reg_file_8x16_pkg.sv
// Shared sizing constants and types for the 8-entry x 16-bit general-purpose register bank.
package reg_file_8x16_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;

    localparam logic [DATA_W-1:0] REG_RESET_VAL = 16'h0000;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/reg_file_8x16_register.sv
// Single storage word: D register with load enable and asynchronous active-low clear.
module register
    import reg_file_8x16_pkg::*;
#(
    parameter int                WIDTH     = DATA_W,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // With load low the mux selects the held value, so X on d never reaches the flop.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/reg_file_8x16.sv
// Register bank: one synchronous write port, two combinational read ports, no write-through bypass.
module reg_file_8x16
    import reg_file_8x16_pkg::*;
#(
    parameter int DATA_W = reg_file_8x16_pkg::DATA_W,
    parameter int ADDR_W = reg_file_8x16_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out_a,
    output logic [DATA_W-1:0] d_out_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0]  wr_en;
    logic [DATA_W-1:0] reg_val [DEPTH];

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en[i] = wr && (wr_addr == ADDR_W'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_regs
        register #(
            .WIDTH     (DATA_W),
            .RESET_VAL (DATA_W'(REG_RESET_VAL))
        ) u_reg (
            .clk   (clk),
            .reset (reset),
            .load  (wr_en[g]),
            .d     (d_in),
            .q     (reg_val[g])
        );
    end

    // Reads come straight from register state, so a same-cycle write shows only after the edge.
    always_comb begin
        d_out_a = reg_val[rd_addr_a];
        d_out_b = reg_val[rd_addr_b];
    end

endmodule

// File: tb/tb_reg_file_8x16.sv
// Directed bench for reg_file_8x16: driver pushes expected read data, a monitor pops and compares.
module tb_reg_file_8x16;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk;
    logic          reset;
    logic          wr;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] d_in;
    logic [DW-1:0] d_out_a;
    logic [DW-1:0] d_out_b;

    logic [2*DW-1:0] exp_q[$];
    string           name_q[$];
    logic            chk_valid;
    int              n_vec;
    int              n_err;

    reg_file_8x16 #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .wr_addr   (wr_addr),
        .d_in      (d_in),
        .d_out_a   (d_out_a),
        .d_out_b   (d_out_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: the strobe marks a stable read the DUT is presenting
    initial begin
        n_vec = 0;
        n_err = 0;
        forever begin
            @(posedge chk_valid);
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL no_expectation: read a=%h b=%h with empty queue", d_out_a, d_out_b);
            end else begin
                logic [2*DW-1:0] e;
                string           nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if ({d_out_a, d_out_b} !== e) begin
                    n_err++;
                    $display("FAIL %s: got a=%h b=%h, expected a=%h b=%h",
                             nm, d_out_a, d_out_b, e[2*DW-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic check_rd(input logic [AW-1:0] a, input logic [AW-1:0] b,
                            input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                            input string nm);
        rd_addr_a = a;
        rd_addr_b = b;
        #1;
        exp_q.push_back({ea, eb});
        name_q.push_back(nm);
        chk_valid = 1'b1;
        #1;
        chk_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        wr      = 1'b1;
        wr_addr = a;
        d_in    = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    initial begin
        chk_valid = 1'b0;
        wr        = 1'b0;
        wr_addr   = '0;
        d_in      = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        reset     = 1'b1;
        #1 reset  = 1'b0;

        // reset held across the first edge
        for (int i = 0; i < 8; i++) begin
            check_rd(AW'(i), AW'(7 - i), 16'h0000, 16'h0000, "reset_held");
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_rd(AW'(i), AW'(i), 16'h0000, 16'h0000, "reset_released");
        end

        // sequential writes
        do_write(3'd3, 16'hcdef);
        do_write(3'd7, 16'h3210);
        check_rd(3'd3, 3'd7, 16'hcdef, 16'h3210, "seq_write");

        // read during write to another register
        @(negedge clk);
        wr      = 1'b1;
        wr_addr = 3'd5;
        d_in    = 16'h4567;
        check_rd(3'd3, 3'd7, 16'hcdef, 16'h3210, "read_during_write");
        @(posedge clk);
        #1 wr = 1'b0;
        check_rd(3'd1, 3'd5, 16'h0000, 16'h4567, "after_write5");

        // write disabled with garbage address/data
        do_write(3'd0, 16'hba98);
        @(negedge clk);
        wr      = 1'b0;
        wr_addr = 3'd1;
        d_in    = 'x;
        @(posedge clk);
        #1;
        check_rd(3'd1, 3'd5, 16'h0000, 16'h4567, "wr_disabled");
        check_rd(3'd0, 3'd0, 16'hba98, 16'hba98, "same_port_addr");

        // same-address read and write: no bypass
        @(negedge clk);
        wr      = 1'b1;
        wr_addr = 3'd6;
        d_in    = 16'h1234;
        check_rd(3'd6, 3'd3, 16'h0000, 16'hcdef, "no_bypass_before");
        @(posedge clk);
        #1 wr = 1'b0;
        check_rd(3'd6, 3'd6, 16'h1234, 16'h1234, "no_bypass_after");

        // asynchronous reset mid-operation, concurrent write discarded
        @(negedge clk);
        wr      = 1'b1;
        wr_addr = 3'd2;
        d_in    = 16'hffff;
        #1 reset = 1'b0;
        check_rd(3'd3, 3'd6, 16'h0000, 16'h0000, "async_clear");
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            check_rd(AW'(i), AW'(7 - i), 16'h0000, 16'h0000, "reset_mid_op");
        end
        @(negedge clk);
        wr    = 1'b0;
        reset = 1'b1;
        check_rd(3'd2, 3'd0, 16'h0000, 16'h0000, "write_discarded");

        // normal operation after release
        do_write(3'd2, 16'ha5a5);
        check_rd(3'd2, 3'd3, 16'ha5a5, 16'h0000, "post_reset_write");

        #5;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, 0 required", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
